// File: rtl/tile_credit_scheduler.sv
// Frame/tile issue sequencer for the MAC->bias->sigmoid->join pipeline with credit-bounded in-flight tiles.
// Optional stall perf counter enabled by defining TILE_SCHED_PERF_EN.
module tile_credit_scheduler #(
    parameter int TILE_SIZE = 4,
    parameter int D         = 256,
    parameter int N_TILES   = D / TILE_SIZE,
    parameter int CREDITS   = 4,
    parameter int FRM_W     = 16,
    parameter int TIDX_W    = $clog2(N_TILES),
    parameter int CRD_W     = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [FRM_W-1:0]  n_frames,
    input  logic              abort,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic              sof,
    output logic [TIDX_W-1:0] tile_idx,
    input  logic              retire_valid,
    input  logic              retire_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [FRM_W-1:0]  frame_cnt,
    output logic [CRD_W-1:0]  credits,
    output logic              err_retire,
    output logic [31:0]       stall_cycles
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic               fire, ret, start_ok, last_tile, last_frame, run_end;
    logic               abort_seen, issue_valid_nxt, err_set;
    logic [FRM_W-1:0]   frames_req;
    logic [CRD_W-1:0]   credits_nxt;

    assign fire       = issue_valid & issue_ready;
    assign ret        = retire_valid & retire_ready;
    assign start_ok   = (state == IDLE) & start;
    assign last_tile  = (tile_idx == TIDX_W'(N_TILES - 1));
    assign last_frame = ((frame_cnt + FRM_W'(1)) == frames_req);
    assign run_end    = fire & last_tile & last_frame;

    // A retire with every credit already home is a downstream protocol error; hold at the ceiling.
    always_comb begin
        credits_nxt = credits;
        err_set     = 1'b0;
        case ({fire, ret})
            2'b10: credits_nxt = credits - CRD_W'(1);
            2'b01: begin
                if (credits == CRD_W'(CREDITS)) err_set = 1'b1;
                else                            credits_nxt = credits + CRD_W'(1);
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort only takes effect once no offer is left hanging
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (n_frames == '0) ? DONE : ISSUE;
            ISSUE: begin
                if (run_end)                            state_nxt = DRAIN;
                else if (abort && (fire || !issue_valid)) state_nxt = DRAIN;
            end
            DRAIN: if (credits == CRD_W'(CREDITS)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; issue_valid looks at post-update credits so an offer never outruns them
    always_comb begin
        issue_valid_nxt = 1'b0;
        if (state_nxt == ISSUE)
            issue_valid_nxt = (issue_valid & ~issue_ready) | (~abort & (credits_nxt != '0));
        busy = (state == ISSUE) || (state == DRAIN);
        done = (state == DONE);
        sof  = issue_valid & (tile_idx == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid <= 1'b0;
            tile_idx    <= '0;
            frame_cnt   <= '0;
            frames_req  <= '0;
            credits     <= CRD_W'(CREDITS);
            err_retire  <= 1'b0;
            aborted     <= 1'b0;
            abort_seen  <= 1'b0;
        end else begin
            issue_valid <= issue_valid_nxt;
            credits     <= credits_nxt;
            if (err_set) err_retire <= 1'b1;
            if (start_ok) begin
                frames_req <= n_frames;
                tile_idx   <= '0;
                frame_cnt  <= '0;
                aborted    <= 1'b0;
                abort_seen <= 1'b0;
            end else if (fire) begin
                if (last_tile) begin
                    tile_idx  <= '0;
                    frame_cnt <= frame_cnt + FRM_W'(1);
                end else begin
                    tile_idx  <= tile_idx + TIDX_W'(1);
                end
            end
            if (state == ISSUE && state_nxt == DRAIN && !run_end) abort_seen <= 1'b1;
            if (state == DRAIN && state_nxt == DONE) aborted <= abort_seen;
        end
    end

`ifdef TILE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (start_ok)
            stall_cycles <= '0;
        else if (state == ISSUE && (credits == '0 || (issue_valid && !issue_ready)) && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
